// File: rtl/mips_datapath.sv
// mips_datapath: multicycle 32-bit MIPS-subset CPU with a private 512-byte
// big-endian instruction/data memory.
// Ports:
//   Clear - synchronous active-low reset, sampled on rising Clk
//   Clk   - single clock, every state change on the rising edge
// PC_out/nPC_out give a one-instruction branch delay slot: DECODE advances
// PC to nPC, and a taken branch in EXEC only redirects nPC.

module mips_ram (
    input  logic        clk,
    input  logic        mov,
    input  logic        rw,
    input  logic [6:0]  word_addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        MOC
);
    logic [7:0] Mem [0:511];

    // One access per request: MOC blocks repeats until MOV drops.
    always_ff @(posedge clk) begin
        if (!mov) begin
            MOC <= 1'b0;
        end else if (!MOC) begin
            MOC <= 1'b1;
            if (rw) begin
                dout <= {Mem[{word_addr, 2'b00}], Mem[{word_addr, 2'b01}],
                         Mem[{word_addr, 2'b10}], Mem[{word_addr, 2'b11}]};
            end else begin
                Mem[{word_addr, 2'b00}] <= din[31:24];
                Mem[{word_addr, 2'b01}] <= din[23:16];
                Mem[{word_addr, 2'b10}] <= din[15:8];
                Mem[{word_addr, 2'b11}] <= din[7:0];
            end
        end
    end
endmodule

module mips_datapath (
    input logic Clear,
    input logic Clk
);
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_WAIT_IF  = 4'd2,
        S_DECODE   = 4'd3,
        S_EXEC     = 4'd4,
        S_WAIT_MEM = 4'd5,
        S_WB       = 4'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    state_t      st, st_d;
    logic [31:0] PC_out, nPC_out, MAR_out, IR_out;
    logic [31:0] pc_d, npc_d, mar_d, ir_d;
    logic [31:0] mdr_q, mdr_d, a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
    logic [31:0] regs_q [0:31];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic        mov, rw, mem_moc;
    logic [31:0] mem_rdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] sext;

    assign op    = IR_out[31:26];
    assign rs    = IR_out[25:21];
    assign rt    = IR_out[20:16];
    assign rd    = IR_out[15:11];
    assign shamt = IR_out[10:6];
    assign funct = IR_out[5:0];
    assign imm   = IR_out[15:0];
    assign sext  = {{16{imm[15]}}, imm};

    // Memory only decodes a 512-byte, word-aligned window of MAR.
    logic unused_mar_bits;
    assign unused_mar_bits = ^{MAR_out[31:9], MAR_out[1:0]};

    mips_ram RAM (
        .clk       (Clk),
        .mov       (mov),
        .rw        (rw),
        .word_addr (MAR_out[8:2]),
        .din       (mdr_q),
        .dout      (mem_rdata),
        .MOC       (mem_moc)
    );

    always_comb begin
        st_d      = st;
        pc_d      = PC_out;
        npc_d     = nPC_out;
        mar_d     = MAR_out;
        ir_d      = IR_out;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_out_q;
        // MOV is decoded from the state, so it is low whenever st is RESET.
        mov       = 1'b0;
        rw        = 1'b1;

        case (st)
            S_RESET: st_d = S_FETCH;
            S_FETCH: begin
                mar_d = PC_out;
                st_d  = S_WAIT_IF;
            end
            S_WAIT_IF: begin
                mov = 1'b1;
                if (mem_moc) begin
                    ir_d = mem_rdata;
                    st_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = regs_q[rs];
                b_d   = regs_q[rt];
                pc_d  = nPC_out;
                npc_d = nPC_out + 32'd4;
                st_d  = S_EXEC;
            end
            S_EXEC: begin
                st_d = S_FETCH;
                case (op)
                    OP_RTYPE: begin
                        st_d = S_WB;
                        case (funct)
                            FN_SLL:  alu_out_d = b_q << shamt;
                            FN_ADDU: alu_out_d = a_q + b_q;
                            FN_SUBU: alu_out_d = a_q - b_q;
                            FN_AND:  alu_out_d = a_q & b_q;
                            FN_OR:   alu_out_d = a_q | b_q;
                            FN_SLT:  alu_out_d = {31'd0, $signed(a_q) < $signed(b_q)};
                            default: st_d = S_FETCH;
                        endcase
                    end
                    OP_ADDIU: begin
                        alu_out_d = a_q + sext;
                        st_d      = S_WB;
                    end
                    OP_ORI: begin
                        alu_out_d = a_q | {16'd0, imm};
                        st_d      = S_WB;
                    end
                    OP_LUI: begin
                        alu_out_d = {imm, 16'd0};
                        st_d      = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        mar_d = a_q + sext;
                        mdr_d = b_q;
                        st_d  = S_WAIT_MEM;
                    end
                    // PC already holds the delay-slot address here.
                    OP_BEQ: if (a_q == b_q) npc_d = PC_out + {sext[29:0], 2'b00};
                    OP_BNE: if (a_q != b_q) npc_d = PC_out + {sext[29:0], 2'b00};
                    OP_J:   npc_d = {PC_out[31:28], IR_out[25:0], 2'b00};
                    default: ;
                endcase
            end
            S_WAIT_MEM: begin
                mov = 1'b1;
                rw  = (op == OP_LW);
                if (mem_moc) begin
                    if (op == OP_LW) begin
                        mdr_d = mem_rdata;
                        st_d  = S_WB;
                    end else begin
                        st_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OP_RTYPE) ? rd : rt;
                rf_wdata = (op == OP_LW) ? mdr_q : alu_out_q;
                st_d     = S_FETCH;
            end
            default: st_d = S_RESET;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clear) begin
            st        <= S_RESET;
            PC_out    <= '0;
            nPC_out   <= 32'd4;
            MAR_out   <= '0;
            IR_out    <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i[4:0]] <= '0;
            end
        end else begin
            st        <= st_d;
            PC_out    <= pc_d;
            nPC_out   <= npc_d;
            MAR_out   <= mar_d;
            IR_out    <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            if (rf_we && (rf_waddr != '0)) begin
                regs_q[rf_waddr] <= rf_wdata;
            end
        end
    end
endmodule

// File: tb/tb_mips_datapath.sv
module tb_mips_datapath;
    logic Clk = 1'b0;
    logic Clear;

    always #5 Clk = ~Clk;

    mips_datapath dut (
        .Clear (Clear),
        .Clk   (Clk)
    );

    int errors = 0;
    int checks = 0;

    // Architectural reference: memory image, register file, PC/nPC pair.
    logic [7:0]  m_mem [0:511];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_pc, m_npc;

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic mem_clear();
        for (int i = 0; i < 512; i++) begin
            m_mem[i] = 8'h00;
            dut.RAM.Mem[i] <= 8'h00;
        end
    endtask

    task automatic put_word(input int unsigned addr, input logic [31:0] w);
        for (int unsigned k = 0; k < 4; k++) begin
            m_mem[addr + k] = w[31 - 8*k -: 8];
            dut.RAM.Mem[addr + k] <= w[31 - 8*k -: 8];
        end
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] addr);
        logic [8:0] b;
        b = {addr[8:2], 2'b00};
        return {m_mem[b], m_mem[b + 9'd1], m_mem[b + 9'd2], m_mem[b + 9'd3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_pc  = 32'd0;
        m_npc = 32'd4;
    endtask

    // Executes one instruction at ISA level; returns its cycle cost.
    task automatic model_exec(output int cyc, output logic [31:0] ins,
                              output logic [31:0] fetch_pc);
        logic [31:0] a, b, sx, addr, res;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, dst;
        logic        wr;
        logic [8:0]  base;
        fetch_pc = m_pc;
        ins = m_word(m_pc);
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
        a = m_reg[rs]; b = m_reg[rt];
        sx = {{16{ins[15]}}, ins[15:0]};
        m_pc  = m_npc;
        m_npc = m_npc + 32'd4;
        cyc = 5; wr = 1'b0; dst = rt; res = 32'd0;
        case (op)
            6'h00: begin
                dst = rd; wr = 1'b1;
                case (fn)
                    6'h00: res = b << sh;
                    6'h21: res = a + b;
                    6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            6'h09: begin wr = 1'b1; res = a + sx; end
            6'h0D: begin wr = 1'b1; res = a | {16'h0, ins[15:0]}; end
            6'h0F: begin wr = 1'b1; res = {ins[15:0], 16'h0}; end
            6'h23: begin wr = 1'b1; res = m_word(a + sx); end
            6'h2B: begin
                addr = a + sx;
                base = {addr[8:2], 2'b00};
                m_mem[base]        = b[31:24];
                m_mem[base + 9'd1] = b[23:16];
                m_mem[base + 9'd2] = b[15:8];
                m_mem[base + 9'd3] = b[7:0];
                cyc = 7;
            end
            6'h04: if (a == b) m_npc = m_pc + (sx << 2);
            6'h05: if (a != b) m_npc = m_pc + (sx << 2);
            6'h02: m_npc = {m_pc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        if (wr) begin
            cyc = (op == 6'h23) ? 8 : 6;
            if (dst != 5'd0) m_reg[dst] = res;
        end
    endtask

    task automatic restart();
        Clear = 1'b0;
        step(1);
        Clear = 1'b1;
        step(1);
    endtask

    // Runs the DUT from FETCH to the next FETCH (bounded), reporting the
    // cycle count, MAR after FETCH, and IR seen in DECODE.
    task automatic run_one(output int cyc, output logic [31:0] mar_if,
                           output logic [31:0] ir_seen);
        cyc = 0; mar_if = 'x; ir_seen = 'x;
        do begin
            step(1);
            cyc++;
            if (cyc == 1) mar_if = dut.MAR_out;
            if (dut.st == 4'd3) ir_seen = dut.IR_out;
        end while (dut.st != 4'd1 && cyc < 40);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm, off;
        logic [25:0] tgt;
        int unsigned k;
        k = $urandom_range(0, 14);
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7)); sh = 5'($urandom);
        imm = 16'($urandom); tgt = 26'($urandom);
        off = 16'($urandom_range(0, 12)) - 16'd4;
        case (k)
            0:  return {6'h00, rs, rt, rd, sh, 6'h00};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            2:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            3:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            4:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            5:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            6:  return {6'h09, rs, rt, imm};
            7:  return {6'h0D, rs, rt, imm};
            8:  return {6'h0F, 5'd0, rt, imm};
            9:  return {6'h23, rs, rt, imm};
            10: return {6'h2B, rs, rt, imm};
            11: return {6'h04, rs, rt, off};
            12: return {6'h05, rs, rt, off};
            13: return {6'h02, tgt};
            default: return ($urandom_range(0, 1) == 0) ? {6'h3F, tgt}
                                                       : {6'h00, rs, rt, rd, 5'd0, 6'h3F};
        endcase
    endfunction

    task automatic test_reset();
        mem_clear();
        put_word(0, 32'h24010005);
        Clear = 1'b0;
        step(2);
        checks++; if (dut.st !== 4'd0) begin errors++; $display("FAIL reset_st: got %0d expected 0", dut.st); end
        checks++; if (dut.PC_out !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", dut.PC_out); end
        checks++; if (dut.nPC_out !== 32'd4) begin errors++; $display("FAIL reset_npc: got %h expected 4", dut.nPC_out); end
        checks++; if (dut.MAR_out !== 32'd0) begin errors++; $display("FAIL reset_mar: got %h expected 0", dut.MAR_out); end
        checks++; if (dut.IR_out !== 32'd0) begin errors++; $display("FAIL reset_ir: got %h expected 0", dut.IR_out); end
        checks++; if (dut.RAM.MOC !== 1'b0) begin errors++; $display("FAIL reset_moc: got %b expected 0", dut.RAM.MOC); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.regs_q[i] !== 32'd0) begin errors++; $display("FAIL reset_reg[%0d]: got %h expected 0", i, dut.regs_q[i]); end
        end
        Clear = 1'b1;
        step(1);
        checks++; if (dut.st !== 4'd1) begin errors++; $display("FAIL release_st1: got %0d expected 1", dut.st); end
        step(1);
        checks++; if (dut.st !== 4'd2) begin errors++; $display("FAIL release_st2: got %0d expected 2", dut.st); end
        checks++; if (dut.MAR_out !== 32'd0) begin errors++; $display("FAIL release_mar: got %h expected 0", dut.MAR_out); end
    endtask

    task automatic test_fetch_imm();
        mem_clear();
        put_word(0, 32'h24010005);
        restart();
        checks++; if (dut.st !== 4'd1) begin errors++; $display("FAIL fetch_start_st: got %0d expected 1", dut.st); end
        step(3);
        checks++; if (dut.st !== 4'd3) begin errors++; $display("FAIL fetch_decode_st: got %0d expected 3", dut.st); end
        checks++; if (dut.IR_out !== 32'h24010005) begin errors++; $display("FAIL fetch_ir: got %h expected 24010005", dut.IR_out); end
        step(1);
        checks++; if (dut.PC_out !== 32'd4) begin errors++; $display("FAIL decode_pc: got %h expected 4", dut.PC_out); end
        checks++; if (dut.nPC_out !== 32'd8) begin errors++; $display("FAIL decode_npc: got %h expected 8", dut.nPC_out); end
        step(2);
        checks++; if (dut.st !== 4'd1) begin errors++; $display("FAIL imm_done_st: got %0d expected 1", dut.st); end
        checks++; if (dut.regs_q[1] !== 32'd5) begin errors++; $display("FAIL imm_r1: got %h expected 5", dut.regs_q[1]); end
        step(1);
        checks++; if (dut.MAR_out !== 32'd4) begin errors++; $display("FAIL next_fetch_mar: got %h expected 4", dut.MAR_out); end
    endtask

    task automatic test_program();
        int unsigned fetch_tbl [13] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C,
                                        32'h20, 32'h24, 32'h28, 32'h40, 32'h44, 32'h48};
        int cyc_tbl [13] = '{6, 6, 6, 6, 5, 6, 5, 6, 5, 6, 6, 5, 6};
        int cyc;
        logic [31:0] mar_if, ir_seen;
        mem_clear();
        put_word(32'h00, 32'h24010005);  // addiu r1,r0,5
        put_word(32'h04, 32'h24020007);  // addiu r2,r0,7
        put_word(32'h08, 32'h00221821);  // addu r3,r1,r2
        put_word(32'h0C, 32'h00222023);  // subu r4,r1,r2
        put_word(32'h10, 32'h10000002);  // beq r0,r0,+2
        put_word(32'h14, 32'h0081282A);  // slt r5,r4,r1 (delay slot)
        put_word(32'h18, 32'h24090001);  // skipped
        put_word(32'h1C, 32'h14000005);  // bne r0,r0 (not taken)
        put_word(32'h20, 32'h3C061234);  // lui r6,0x1234
        put_word(32'h24, 32'h08000010);  // j 0x40
        put_word(32'h28, 32'h34C65678);  // ori r6,r6,0x5678 (delay slot)
        put_word(32'h2C, 32'h24090002);  // skipped
        put_word(32'h40, 32'h24000009);  // addiu r0,r0,9
        put_word(32'h44, 32'hFC000000);  // unknown opcode 0x3F
        put_word(32'h48, 32'h2408FFFF);  // addiu r8,r0,-1
        restart();
        for (int n = 0; n < 13; n++) begin
            run_one(cyc, mar_if, ir_seen);
            checks++; if (cyc !== cyc_tbl[n]) begin errors++; $display("FAIL prog_cycles[%0d]: got %0d expected %0d", n, cyc, cyc_tbl[n]); end
            checks++; if (mar_if !== fetch_tbl[n]) begin errors++; $display("FAIL prog_fetch[%0d]: got %h expected %h", n, mar_if, fetch_tbl[n]); end
        end
        checks++; if (dut.regs_q[3] !== 32'd12) begin errors++; $display("FAIL addu_r3: got %h expected 0000000c", dut.regs_q[3]); end
        checks++; if (dut.regs_q[4] !== 32'hFFFFFFFE) begin errors++; $display("FAIL subu_r4: got %h expected fffffffe", dut.regs_q[4]); end
        checks++; if (dut.regs_q[5] !== 32'd1) begin errors++; $display("FAIL slt_r5: got %h expected 1", dut.regs_q[5]); end
        checks++; if (dut.regs_q[6] !== 32'h12345678) begin errors++; $display("FAIL lui_ori_r6: got %h expected 12345678", dut.regs_q[6]); end
        checks++; if (dut.regs_q[8] !== 32'hFFFFFFFF) begin errors++; $display("FAIL addiu_neg_r8: got %h expected ffffffff", dut.regs_q[8]); end
        checks++; if (dut.regs_q[9] !== 32'd0) begin errors++; $display("FAIL skipped_r9: got %h expected 0", dut.regs_q[9]); end
        checks++; if (dut.regs_q[0] !== 32'd0) begin errors++; $display("FAIL r0_zero: got %h expected 0", dut.regs_q[0]); end
    endtask

    task automatic test_mem_ops();
        int cyc;
        logic [31:0] mar_if, ir_seen;
        logic [31:0] stored;
        mem_clear();
        put_word(32'h00, 32'h3C061234);  // lui r6,0x1234
        put_word(32'h04, 32'h34C65678);  // ori r6,r6,0x5678
        put_word(32'h08, 32'hAC060040);  // sw r6,64(r0)
        put_word(32'h0C, 32'h8C070040);  // lw r7,64(r0)
        restart();
        run_one(cyc, mar_if, ir_seen);
        run_one(cyc, mar_if, ir_seen);
        run_one(cyc, mar_if, ir_seen);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL sw_cycles: got %0d expected 7", cyc); end
        stored = {dut.RAM.Mem[64], dut.RAM.Mem[65], dut.RAM.Mem[66], dut.RAM.Mem[67]};
        checks++; if (stored !== 32'h12345678) begin errors++; $display("FAIL sw_bytes: got %h expected 12345678", stored); end
        run_one(cyc, mar_if, ir_seen);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL lw_cycles: got %0d expected 8", cyc); end
        checks++; if (dut.regs_q[7] !== 32'h12345678) begin errors++; $display("FAIL lw_r7: got %h expected 12345678", dut.regs_q[7]); end
    endtask

    task automatic test_reset_mid_mem();
        int cyc, waited;
        logic [31:0] mar_if, ir_seen;
        mem_clear();
        put_word(32'h00, 32'h24010003);  // addiu r1,r0,3
        put_word(32'h04, 32'hAC010100);  // sw r1,0x100(r0)
        restart();
        run_one(cyc, mar_if, ir_seen);
        waited = 0;
        while (dut.st != 4'd5 && waited < 10) begin
            step(1);
            waited++;
        end
        checks++; if (dut.st !== 4'd5) begin errors++; $display("FAIL reach_wait_mem: got st %0d expected 5", dut.st); end
        Clear = 1'b0;
        step(1);
        checks++; if (dut.st !== 4'd0) begin errors++; $display("FAIL midmem_st: got %0d expected 0", dut.st); end
        checks++; if (dut.PC_out !== 32'd0) begin errors++; $display("FAIL midmem_pc: got %h expected 0", dut.PC_out); end
        checks++; if (dut.nPC_out !== 32'd4) begin errors++; $display("FAIL midmem_npc: got %h expected 4", dut.nPC_out); end
        checks++; if (dut.regs_q[1] !== 32'd0) begin errors++; $display("FAIL midmem_r1: got %h expected 0", dut.regs_q[1]); end
        Clear = 1'b1;
        step(1);
        checks++; if (dut.st !== 4'd1) begin errors++; $display("FAIL midmem_restart_st: got %0d expected 1", dut.st); end
        checks++; if (dut.RAM.MOC !== 1'b0) begin errors++; $display("FAIL midmem_moc: got %b expected 0", dut.RAM.MOC); end
        run_one(cyc, mar_if, ir_seen);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL midmem_refetch_cycles: got %0d expected 6", cyc); end
        checks++; if (mar_if !== 32'd0) begin errors++; $display("FAIL midmem_refetch_addr: got %h expected 0", mar_if); end
        checks++; if (dut.regs_q[1] !== 32'd3) begin errors++; $display("FAIL midmem_rerun_r1: got %h expected 3", dut.regs_q[1]); end
    endtask

    task automatic test_random();
        int cyc, ecyc, bad_bytes, first_bad;
        logic [31:0] mar_if, ir_seen, eins, efetch;
        mem_clear();
        model_reset();
        for (int unsigned i = 0; i < 48; i++) put_word(i * 4, gen_instr());
        restart();
        for (int n = 0; n < 80; n++) begin
            model_exec(ecyc, eins, efetch);
            run_one(cyc, mar_if, ir_seen);
            checks++; if (cyc !== ecyc) begin errors++; $display("FAIL rnd_cycles[%0d]: got %0d expected %0d (ins %h)", n, cyc, ecyc, eins); end
            checks++; if (mar_if !== efetch) begin errors++; $display("FAIL rnd_fetch[%0d]: got %h expected %h", n, mar_if, efetch); end
            checks++; if (ir_seen !== eins) begin errors++; $display("FAIL rnd_ir[%0d]: got %h expected %h", n, ir_seen, eins); end
            checks++; if (dut.PC_out !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, dut.PC_out, m_pc); end
            checks++; if (dut.nPC_out !== m_npc) begin errors++; $display("FAIL rnd_npc[%0d]: got %h expected %h", n, dut.nPC_out, m_npc); end
            for (int r = 0; r < 32; r++) begin
                checks++;
                if (dut.regs_q[r] !== m_reg[r]) begin
                    errors++;
                    $display("FAIL rnd_reg[%0d] r%0d: got %h expected %h (ins %h)", n, r, dut.regs_q[r], m_reg[r], eins);
                end
            end
        end
        bad_bytes = 0; first_bad = -1;
        for (int i = 0; i < 512; i++) begin
            if (dut.RAM.Mem[i] !== m_mem[i]) begin
                bad_bytes++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++;
        if (bad_bytes != 0) begin
            errors++;
            $display("FAIL rnd_memory: %0d bytes differ, first at %0d got %h expected %h",
                     bad_bytes, first_bad, dut.RAM.Mem[first_bad], m_mem[first_bad]);
        end
    endtask

    initial begin
        Clear = 1'b0;
        test_reset();
        test_fetch_imm();
        test_program();
        test_mem_ops();
        test_reset_mid_mem();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
